// File: rtl/bnn_pkg.sv
// Shared types and helpers for the streaming BNN convolution layer.
// Holds the FSM state type, clog2, popcount and the kernel_in bit-index function.
package bnn_pkg;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_e;

  localparam int POP_MAX_N = 1024;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [POP_MAX_N-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_N; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  // Row r counts from the oldest (top) row, column k from the leftmost column.
  function automatic int weight_index(input int o, input int c, input int r, input int k,
                                      input int in_chanl, input int kernel_width);
    return ((o * in_chanl + c) * kernel_width * kernel_width) + r * kernel_width + k;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount of one binary window against one channel's weights.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int N     = 9,
  parameter int CNT_W = 4
) (
  input  logic [N-1:0]     i_window,
  input  logic [N-1:0]     i_weights,
  output logic [CNT_W-1:0] o_pop
);

  logic [POP_MAX_N-1:0] w_match;

  always_comb begin
    w_match        = '0;
    w_match[N-1:0] = ~(i_window ^ i_weights);
  end

  assign o_pop = CNT_W'(popcount(w_match));

endmodule

// File: rtl/bnn_conv_stream.sv
// Streaming binary convolution (stride 1, no padding) with line buffers and XNOR-popcount.
// Optional feature macro BNN_THRESH_EN: per-channel threshold port thresh_in replaces the majority rule.
module bnn_conv_stream
  import bnn_pkg::*;
#(
  parameter int  IMG_WIDTH    = 30,
  parameter int  IN_CHANL     = 1,
  parameter int  OUT_CHANL    = 8,
  parameter int  KERNEL_WIDTH = 3,
  localparam int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH,
  localparam int N            = KERNEL_SIZE * IN_CHANL,
  localparam int CNT_W        = clog2(N + 1),
  localparam int OUT_WIDTH    = IMG_WIDTH - KERNEL_WIDTH + 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_CHANL-1:0]                    in_data,
  input  logic [KERNEL_SIZE*IN_CHANL*OUT_CHANL-1:0] kernel_in,
`ifdef BNN_THRESH_EN
  input  logic [OUT_CHANL*CNT_W-1:0]             thresh_in,
`endif
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_CHANL-1:0]                   out_data,
  output logic                                   out_last,
  output logic                                   busy
);

  localparam int POS_W = (clog2(IMG_WIDTH) > 0) ? clog2(IMG_WIDTH) : 1;
  localparam int LB_LEN = (KERNEL_WIDTH - 1) * IMG_WIDTH;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(OUT_WIDTH + KERNEL_WIDTH - 2);
  localparam logic [POS_W-1:0] EDGE_POS = POS_W'(KERNEL_WIDTH - 1);
  localparam logic [POS_W-1:0] WRAP_POS = POS_W'(IMG_WIDTH - 1);
`ifndef BNN_THRESH_EN
  localparam logic [CNT_W:0] MAJ = (CNT_W + 1)'(N);
`endif

  logic [POS_W-1:0]    r_row, r_col, w_row_nxt, w_col_nxt;
  state_e              r_state;
  logic [IN_CHANL-1:0] r_lb [LB_LEN];
  logic [IN_CHANL-1:0] r_win [KERNEL_WIDTH][KERNEL_WIDTH-1];
  logic [IN_CHANL-1:0] w_col_px [KERNEL_WIDTH];
  logic [N-1:0]        w_win_vec;
  logic [CNT_W-1:0]    w_pop [OUT_CHANL];
  logic [OUT_CHANL-1:0] w_res;
  logic                w_accept;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_row != '0) || (r_col != '0);

  // Newest window column: older rows come from the far taps of the line buffer.
  always_comb begin
    for (int r = 0; r < KERNEL_WIDTH - 1; r++) begin
      w_col_px[r] = r_lb[(KERNEL_WIDTH - 1 - r) * IMG_WIDTH - 1];
    end
    w_col_px[KERNEL_WIDTH-1] = in_data;
  end

  always_comb begin
    w_win_vec = '0;
    for (int r = 0; r < KERNEL_WIDTH; r++) begin
      for (int c = 0; c < IN_CHANL; c++) begin
        for (int k = 0; k < KERNEL_WIDTH - 1; k++) begin
          w_win_vec[weight_index(0, c, r, k, IN_CHANL, KERNEL_WIDTH)] = r_win[r][k][c];
        end
        w_win_vec[weight_index(0, c, r, KERNEL_WIDTH - 1, IN_CHANL, KERNEL_WIDTH)] = w_col_px[r][c];
      end
    end
  end

  for (genvar o = 0; o < OUT_CHANL; o++) begin : g_chan
    bnn_xnor_popcount #(.N(N), .CNT_W(CNT_W)) u_pop (
      .i_window (w_win_vec),
      .i_weights(kernel_in[o*N +: N]),
      .o_pop    (w_pop[o])
    );
`ifdef BNN_THRESH_EN
    assign w_res[o] = (w_pop[o] >= thresh_in[o*CNT_W +: CNT_W]);
`else
    assign w_res[o] = ({w_pop[o], 1'b0} >= MAJ);
`endif
  end

  always_comb begin
    w_col_nxt = r_col + POS_W'(1);
    w_row_nxt = r_row;
    if (r_col == WRAP_POS) begin
      w_col_nxt = '0;
      w_row_nxt = (r_row == WRAP_POS) ? '0 : r_row + POS_W'(1);
    end else begin
      w_row_nxt = r_row;
    end
  end

  // Pixel storage follows accepted beats only; stale contents never reach an emitted window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0] <= in_data;
      for (int i = 1; i < LB_LEN; i++) r_lb[i] <= r_lb[i-1];
      for (int r = 0; r < KERNEL_WIDTH; r++) begin
        for (int j = 0; j < KERNEL_WIDTH - 2; j++) r_win[r][j] <= r_win[r][j+1];
        r_win[r][KERNEL_WIDTH-2] <= w_col_px[r];
      end
    end
  end

  // r_state is the FILL/RUN decode of the position the next accepted beat will occupy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_col     <= '0;
      r_state   <= FILL;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      r_row     <= '0;
      r_col     <= '0;
      r_state   <= FILL;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (w_accept) begin
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_state <= ((w_row_nxt >= EDGE_POS) && (w_col_nxt >= EDGE_POS)) ? RUN : FILL;
      case (r_state)
        RUN: begin
          out_valid <= 1'b1;
          out_data  <= w_res;
          out_last  <= (r_row == LAST_POS) && (r_col == LAST_POS);
        end
        FILL: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bnn_conv_stream.sv
// Directed scoreboard bench for bnn_conv_stream (5x5 image, 3x3 kernel, 1 in / 2 out channels).
// Builds with or without BNN_THRESH_EN; the threshold model follows the same macro.
module tb_bnn_conv_stream;

  localparam int W  = 5;
  localparam int K  = 3;
  localparam int IC = 1;
  localparam int OC = 2;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [0:0]  in_data;
  logic [1:0]  out_data;
  logic [17:0] kern;
`ifdef BNN_THRESH_EN
  logic [7:0]  thresh;
`endif

  bnn_conv_stream #(.IMG_WIDTH(W), .IN_CHANL(IC), .OUT_CHANL(OC), .KERNEL_WIDTH(K)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .kernel_in(kern),
`ifdef BNN_THRESH_EN
    .thresh_in(thresh),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] sb[$];
  logic [1:0] rx[$];
  logic       m_img [W][W];
  logic       frame_px [W*W];
  int         m_row, m_col, acc, n_last, first_beat, fcyc, bp_cycles;
  bit         seen_first;
  logic       exp_b2b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_out(input int row, input int col);
    logic [1:0] res;
    int pop;
    res = 2'b00;
    for (int o = 0; o < OC; o++) begin
      pop = 0;
      for (int r = 0; r < K; r++)
        for (int k = 0; k < K; k++)
          if (m_img[row-2+r][col-2+k] == kern[o*9 + r*3 + k]) pop++;
`ifdef BNN_THRESH_EN
      res[o] = (pop >= int'(thresh[o*4 +: 4]));
`else
      res[o] = (2 * pop >= 9);
`endif
    end
    return res;
  endfunction

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    sb.delete();
  endtask

  task automatic model_accept(input logic px);
    m_img[m_row][m_col] = px;
    acc++;
    if (m_row >= 2 && m_col >= 2) sb.push_back({(m_row == 4 && m_col == 4), model_out(m_row, m_col)});
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == W - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic start_frame();
    rx.delete();
    n_last = 0;
    seen_first = 1'b0;
  endtask

  // One clock: check output handshake, update model from input handshake, advance.
  task automatic tick();
    logic [2:0] e;
    #1;
    if (out_valid && out_ready) begin
      n_tests++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed out_valid=1 expected no pending output");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        assert ({out_last, out_data} === e) else begin
          n_fail++;
          $error("FAIL out_pixel%0d: observed last,data=%b expected %b", rx.size(), {out_last, out_data}, e);
        end
      end
      if (!seen_first) begin
        seen_first = 1'b1;
        first_beat = m_row * W + m_col;
      end
      rx.push_back(out_data);
      if (out_last) n_last++;
    end
    if (clear) model_reset();
    else if (in_valid && in_ready) model_accept(in_data[0]);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int nbeats, input bit rnd);
    int tgt, cyc;
    logic [1:0] held;
    tgt = acc + nbeats;
    cyc = 0;
    while (acc < tgt && cyc < 400) begin
      in_valid  = 1'b1;
      in_data   = frame_px[m_row*W + m_col];
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bp_cycles > 0 && out_valid) begin
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < bp_cycles; i++) begin
          #1;
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_hold", 32'(out_data), 32'(held));
          tick();
          cyc++;
        end
        bp_cycles = 0;
        out_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fcyc = cyc;
    chk("feed_count", 32'(acc), 32'(tgt));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    kern = 18'h001FF; bp_cycles = 0; acc = 0;
`ifdef BNN_THRESH_EN
    thresh = {4'd5, 4'd5};
`endif
    model_reset();
    start_frame();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Partial frame, then asynchronous reset in the middle of it.
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'($urandom_range(0, 1));
    feed(7, 1'b0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // All-ones frame: ch0 weights all 1, ch1 weights all 0.
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'b1;
    start_frame();
    feed(25, 1'b0);
    drain();
    chk("ones_first_beat", 32'(first_beat), 32'd13);
    chk("ones_count", 32'(rx.size()), 32'd9);
    chk("ones_last_count", 32'(n_last), 32'd1);
    chk("ones_data0", 32'(rx[0]), 32'h1);
    chk("ones_data8", 32'(rx[8]), 32'h1);

    // Majority boundary: window (2,2) holds 5 ones, window (2,3) holds 4.
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'b0;
    frame_px[0] = 1'b1; frame_px[1] = 1'b1; frame_px[2] = 1'b1;
    frame_px[6] = 1'b1; frame_px[7] = 1'b1;
    start_frame();
    feed(25, 1'b0);
    drain();
    chk("thr_count", 32'(rx.size()), 32'd9);
    chk("thr_pop5", 32'(rx[0][0]), 32'd1);
    chk("thr_pop4", 32'(rx[1][0]), 32'd0);

    // Random weights and pixels with random downstream readiness.
    kern = 18'($urandom());
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'($urandom_range(0, 1));
    start_frame();
    feed(25, 1'b1);
    drain();
    chk("rnd_count", 32'(rx.size()), 32'd9);
    chk("rnd_last_count", 32'(n_last), 32'd1);

    // Four cycles of backpressure on the first output.
    kern = 18'($urandom());
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'($urandom_range(0, 1));
    start_frame();
    bp_cycles = 4;
    feed(25, 1'b0);
    drain();
    chk("bp_count", 32'(rx.size()), 32'd9);
    chk("bp_last_count", 32'(n_last), 32'd1);

    // Frame abort with a result held, clear colliding with in_valid.
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'($urandom_range(0, 1));
    start_frame();
    feed(18, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("clr_held", 32'(out_valid), 32'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    tick();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'($urandom_range(0, 1));
    start_frame();
    feed(25, 1'b0);
    drain();
    chk("clr_count", 32'(rx.size()), 32'd9);
    chk("clr_last_count", 32'(n_last), 32'd1);

    // Two back-to-back frames; first window has pop_0 = 3.
    kern = 18'h001FF;
`ifdef BNN_THRESH_EN
    thresh = {4'd5, 4'd3};
    exp_b2b = 1'b1;
`else
    exp_b2b = 1'b0;
`endif
    for (int i = 0; i < W*W; i++) frame_px[i] = 1'b0;
    frame_px[0] = 1'b1; frame_px[6] = 1'b1; frame_px[12] = 1'b1;
    start_frame();
    feed(50, 1'b0);
    chk("b2b_cycles", 32'(fcyc), 32'd50);
    drain();
    chk("b2b_count", 32'(rx.size()), 32'd18);
    chk("b2b_last_count", 32'(n_last), 32'd2);
    chk("b2b_pop3_f1", 32'(rx[0][0]), 32'(exp_b2b));
    chk("b2b_pop3_f2", 32'(rx[9][0]), 32'(exp_b2b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
